// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache bus arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32'd64;
  localparam int unsigned DATA_W_DEF = 32'd64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef logic gid_t;

  localparam gid_t GID_I = 1'b0;
  localparam gid_t GID_D = 1'b1;

  function automatic gid_t gid_of(input arb_state_e s);
    gid_t id;
    if (s == GNT_D) begin
      id = GID_D;
    end else begin
      id = GID_I;
    end
    return id;
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Bundle of cache-side and memory-side channels around the cache bus arbiter.
// slave is the arbiter's view; master is the view of the caches plus memory bridge.
interface cache_bus_arbiter_if #(
  parameter int unsigned ADDR_W = cache_arb_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = cache_arb_pkg::DATA_W_DEF
);
  logic              ic_r_valid;
  logic [ADDR_W-1:0] ic_r_raddr;
  logic [DATA_W-1:0] ic_r_rdata;
  logic              ic_r_rlast;
  logic              ic_r_ready;

  logic              dc_r_valid;
  logic [ADDR_W-1:0] dc_r_raddr;
  logic [DATA_W-1:0] dc_r_rdata;
  logic              dc_r_rlast;
  logic              dc_r_ready;
  logic              dc_w_valid;
  logic [ADDR_W-1:0] dc_w_waddr;
  logic [DATA_W-1:0] dc_w_wdata;
  logic              dc_w_wlast;
  logic              dc_w_ready;
  logic              dc_b_ready;
  logic              dc_b_valid;

  logic              mem_r_valid;
  logic [ADDR_W-1:0] mem_r_raddr;
  logic [DATA_W-1:0] mem_r_rdata;
  logic              mem_r_rlast;
  logic              mem_r_ready;
  logic              mem_w_valid;
  logic [ADDR_W-1:0] mem_w_waddr;
  logic [DATA_W-1:0] mem_w_wdata;
  logic              mem_w_wlast;
  logic              mem_w_ready;
  logic              mem_b_valid;
  logic              mem_b_ready;

  modport slave (
    input  ic_r_valid, ic_r_raddr,
    input  dc_r_valid, dc_r_raddr, dc_w_valid, dc_w_waddr, dc_w_wdata, dc_w_wlast, dc_b_ready,
    input  mem_r_rdata, mem_r_rlast, mem_r_ready, mem_w_ready, mem_b_valid,
    output ic_r_rdata, ic_r_rlast, ic_r_ready,
    output dc_r_rdata, dc_r_rlast, dc_r_ready, dc_w_ready, dc_b_valid,
    output mem_r_valid, mem_r_raddr, mem_w_valid, mem_w_waddr, mem_w_wdata, mem_w_wlast, mem_b_ready
  );

  modport master (
    output ic_r_valid, ic_r_raddr,
    output dc_r_valid, dc_r_raddr, dc_w_valid, dc_w_waddr, dc_w_wdata, dc_w_wlast, dc_b_ready,
    output mem_r_rdata, mem_r_rlast, mem_r_ready, mem_w_ready, mem_b_valid,
    input  ic_r_rdata, ic_r_rlast, ic_r_ready,
    input  dc_r_rdata, dc_r_rlast, dc_r_ready, dc_w_ready, dc_b_valid,
    input  mem_r_valid, mem_r_raddr, mem_w_valid, mem_w_waddr, mem_w_wdata, mem_w_wlast, mem_b_ready
  );
endinterface

// File: rtl/cache_arb_pick.sv
// Combinational grant selection between ICache and DCache requests.
// CACHE_ARB_RR_EN selects round-robin on contention; otherwise the DCache always wins.
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  gid_t last_gnt_i,
  output logic gnt_valid_o,
  output gid_t gnt_id_o
);
  gid_t contend_id_s;

`ifdef CACHE_ARB_RR_EN
  assign contend_id_s = (last_gnt_i == GID_D) ? GID_I : GID_D;
`else
  // last_gnt is kept by the top for debug only in this build
  logic last_gnt_unused_s;
  assign last_gnt_unused_s = last_gnt_i;
  assign contend_id_s      = GID_D;
`endif

  always_comb begin
    gnt_valid_o = ic_req_i | dc_req_i;
    gnt_id_o    = GID_I;
    if (ic_req_i && dc_req_i) begin
      gnt_id_o = contend_id_s;
    end else if (dc_req_i) begin
      gnt_id_o = GID_D;
    end else begin
      gnt_id_o = GID_I;
    end
  end
endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares the memory-side cache bus between ICache and DCache; grant is held until all
// transactions issued under it complete. Round-robin contention via CACHE_ARB_RR_EN.
module cache_bus_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic                clock,
  input logic                reset,
  cache_bus_arbiter_if.slave bus
);
  arb_state_e state_q, state_d;
  gid_t       last_gnt_q, last_gnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       wr_pend_q, wr_pend_d;

  logic       ic_req_s, dc_req_s, gnt_valid_s;
  gid_t       gnt_id_s;
  logic       rd_fire_s, b_fire_s;

  logic              mem_r_valid_s;
  logic [ADDR_W-1:0] mem_r_raddr_s;
  logic              mem_w_valid_s;
  logic [ADDR_W-1:0] mem_w_waddr_s;
  logic [DATA_W-1:0] mem_w_wdata_s;
  logic              mem_w_wlast_s;
  logic              mem_b_ready_s;
  logic              ic_r_ready_s, ic_r_rlast_s;
  logic              dc_r_ready_s, dc_r_rlast_s;
  logic              dc_w_ready_s, dc_b_valid_s;
  logic [DATA_W-1:0] rdata_s;

  assign ic_req_s = bus.ic_r_valid;
  assign dc_req_s = bus.dc_r_valid | bus.dc_w_valid;

  cache_arb_pick u_pick (
    .ic_req_i    (ic_req_s),
    .dc_req_i    (dc_req_s),
    .last_gnt_i  (last_gnt_q),
    .gnt_valid_o (gnt_valid_s),
    .gnt_id_o    (gnt_id_s)
  );

  always_comb begin
    mem_r_valid_s = 1'b0;
    mem_r_raddr_s = '0;
    mem_w_valid_s = 1'b0;
    mem_w_waddr_s = '0;
    mem_w_wdata_s = '0;
    mem_w_wlast_s = 1'b0;
    mem_b_ready_s = 1'b0;
    ic_r_ready_s  = 1'b0;
    ic_r_rlast_s  = 1'b0;
    dc_r_ready_s  = 1'b0;
    dc_r_rlast_s  = 1'b0;
    dc_w_ready_s  = 1'b0;
    dc_b_valid_s  = 1'b0;
    rdata_s       = '0;
    case (state_q)
      GNT_I: begin
        mem_r_valid_s = bus.ic_r_valid;
        mem_r_raddr_s = bus.ic_r_raddr;
        ic_r_ready_s  = bus.mem_r_ready;
        ic_r_rlast_s  = bus.mem_r_rlast;
        rdata_s       = bus.mem_r_rdata;
      end
      GNT_D: begin
        mem_r_valid_s = bus.dc_r_valid;
        mem_r_raddr_s = bus.dc_r_raddr;
        mem_w_valid_s = bus.dc_w_valid;
        mem_w_waddr_s = bus.dc_w_waddr;
        mem_w_wdata_s = bus.dc_w_wdata;
        mem_w_wlast_s = bus.dc_w_wlast;
        mem_b_ready_s = bus.dc_b_ready;
        dc_r_ready_s  = bus.mem_r_ready;
        dc_r_rlast_s  = bus.mem_r_rlast;
        dc_w_ready_s  = bus.mem_w_ready;
        dc_b_valid_s  = bus.mem_b_valid;
        rdata_s       = bus.mem_r_rdata;
      end
      default: begin
        mem_r_valid_s = 1'b0;
      end
    endcase
  end

  assign rd_fire_s = mem_r_valid_s & bus.mem_r_ready & bus.mem_r_rlast;
  assign b_fire_s  = bus.mem_b_valid & mem_b_ready_s;

  // Next state: grant from IDLE, retire pending channels, release once nothing is pending.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rd_pend_d  = rd_pend_q;
    wr_pend_d  = wr_pend_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          if (gnt_id_s == GID_D) begin
            state_d   = GNT_D;
            rd_pend_d = bus.dc_r_valid;
            wr_pend_d = bus.dc_w_valid;
          end else begin
            state_d   = GNT_I;
            rd_pend_d = bus.ic_r_valid;
            wr_pend_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        rd_pend_d = rd_pend_q & ~rd_fire_s;
        wr_pend_d = wr_pend_q & ~b_fire_s;
        if (!rd_pend_d && !wr_pend_d) begin
          state_d    = IDLE;
          last_gnt_d = gid_of(state_q);
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d   = IDLE;
        rd_pend_d = 1'b0;
        wr_pend_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; an in-flight burst is simply dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      last_gnt_q <= GID_I;
      rd_pend_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      wr_pend_q  <= wr_pend_d;
    end
  end

  assign bus.mem_r_valid = mem_r_valid_s;
  assign bus.mem_r_raddr = mem_r_raddr_s;
  assign bus.mem_w_valid = mem_w_valid_s;
  assign bus.mem_w_waddr = mem_w_waddr_s;
  assign bus.mem_w_wdata = mem_w_wdata_s;
  assign bus.mem_w_wlast = mem_w_wlast_s;
  assign bus.mem_b_ready = mem_b_ready_s;
  assign bus.ic_r_ready  = ic_r_ready_s;
  assign bus.ic_r_rlast  = ic_r_rlast_s;
  assign bus.ic_r_rdata  = rdata_s;
  assign bus.dc_r_ready  = dc_r_ready_s;
  assign bus.dc_r_rlast  = dc_r_rlast_s;
  assign bus.dc_r_rdata  = rdata_s;
  assign bus.dc_w_ready  = dc_w_ready_s;
  assign bus.dc_b_valid  = dc_b_valid_s;
endmodule
